systolic2x2_ctrl: RTL

Sequencer for the 2x2 weight-stationary systolic MAC array. It accepts a weight set and a job of K input vectors. It then drives the array through weight load, accumulator clear, skewed vector feed and pipeline drain, and returns the 2x2 accumulated result over a valid/ready port. It sits between the host/DMA streams and the array instance, and is the only agent that drives the array's control inputs.

---
 rtl/systolic2x2_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/systolic2x2_ctrl.sv
// systolic2x2_ctrl: sequences weight load, accumulator clear, skewed feed and drain of a 2x2 systolic MAC array
module systolic2x2_ctrl #(
    parameter int DW   = 16,
    parameter int ACCW = 32,
    parameter int KW   = 8,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [4*DW-1:0]   cfg_weight,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [KW-1:0]     job_k,
    input  logic              vin_valid,
    output logic              vin_ready,
    input  logic [2*DW-1:0]   vin_data,
    output logic              arr_wen,
    output logic [4*DW-1:0]   arr_weight,
    output logic              arr_clr,
    output logic [2*DW-1:0]   arr_in,
    output logic [1:0]        arr_in_vld,
    input  logic [4*ACCW-1:0] arr_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*ACCW-1:0] res_data
);
    localparam int DCW = $clog2(LAT + 3);

    typedef enum logic [2:0] {IDLE, LOADW, CLEAR, FEED, DRAIN, RESULT} state_t;

    state_t         state;
    logic           loaded;
    logic [KW-1:0]  k;
    logic [KW-1:0]  rcv;
    logic [DCW-1:0] dcnt;
    logic [DW-1:0]  l0, l1, sk;
    logic           v0, v1, skv;
    logic           vin_acc;

    // cfg_ready is masked while reset is held so every output reads 0 during reset
    assign cfg_ready  = rst && state == IDLE;
    assign job_ready  = state == IDLE && loaded && !cfg_valid;
    assign vin_ready  = state == FEED && rcv < k;
    assign vin_acc    = vin_valid && vin_ready;
    assign arr_in     = {l1, l0};
    assign arr_in_vld = {v1, v0};

    // control FSM: weight load, clear, feed count, drain count and result hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            loaded     <= 1'b0;
            arr_weight <= '0;
            k          <= '0;
            rcv        <= '0;
            dcnt       <= '0;
            arr_wen    <= 1'b0;
            arr_clr    <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        arr_weight <= cfg_weight;
                        arr_wen    <= 1'b1;
                        state      <= LOADW;
                    end else if (job_valid && loaded) begin
                        k       <= job_k;
                        rcv     <= '0;
                        arr_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                LOADW: begin
                    arr_wen <= 1'b0;
                    loaded  <= 1'b1;
                    state   <= IDLE;
                end
                CLEAR: begin
                    arr_clr <= 1'b0;
                    dcnt    <= '0;
                    state   <= k == '0 ? DRAIN : FEED;
                end
                FEED: begin
                    if (vin_acc) begin
                        rcv <= rcv + KW'(1);
                        if (rcv == k - KW'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcnt == DCW'(LAT + 1)) begin
                        res_data  <= arr_out;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // lane0 issues the accepted x0 next cycle; x1 waits one more cycle in the skew register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l0  <= '0;
            v0  <= 1'b0;
            sk  <= '0;
            skv <= 1'b0;
            l1  <= '0;
            v1  <= 1'b0;
        end else begin
            l0  <= vin_acc ? vin_data[DW-1:0] : '0;
            v0  <= vin_acc;
            sk  <= vin_acc ? vin_data[2*DW-1:DW] : '0;
            skv <= vin_acc;
            l1  <= sk;
            v1  <= skv;
        end
    end
endmodule
